fifo_umbral: RTL and testbench

//  Synchronous FIFO with programmable almost-empty/almost-full thresholds.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 28 ++
 rtl/fifo_umbral.sv | 123 ++++++++++++
 tb/tb_fifo_umbral.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the threshold FIFO: payload width, depth and count width.
// CNT_W is one bit wider than the address so the count can reach DEPTH.
package fifo_pkg;

  localparam int FIFO_DATA_W = 6;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the pointers decide what is valid.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-empty/almost-full thresholds and a sticky error flag.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic [ADDR_W-1:0] umbral_L,
  input  logic [ADDR_W-1:0] umbral_H,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              error_q, error_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] rdata;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign almost_empty = (count_q <= {1'b0, umbral_L});
  assign almost_full  = (count_q >= {1'b0, umbral_H});
  assign error        = error_q;

  // When full, a simultaneous pop frees the slot the push lands in.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      count_d = count_q - 1'b1;
    end
    if ((wr_en && full && !rd_en) || (rd_en && empty)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out  = rdata;
  assign valid_out = !empty;
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_out_d = data_out_q;
    valid_d    = rd_acc;
    if (rd_acc) begin
      data_out_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
`endif

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed plus random checks of fifo_umbral against a queue-based model.
// Follows FIFO_FWFT_EN the same way the design does.
module tb_fifo_umbral;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [ADDR_W-1:0] umbral_L = 3'd2;
  logic [ADDR_W-1:0] umbral_H = 3'd6;
  logic              empty, full, almost_empty, almost_full, error;

  fifo_umbral #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .umbral_L     (umbral_L),
    .umbral_H     (umbral_H),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] q[$];
  logic              m_error = 1'b0;
  logic              m_valid = 1'b0;
  logic [DATA_W-1:0] m_data  = '0;
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= int'(umbral_L)));
    chk({tag, ":almost_full"}, 32'(almost_full), 32'(n >= int'(umbral_H)));
    chk({tag, ":error"}, 32'(error), 32'(m_error));
    if (FWFT) begin
      chk({tag, ":valid"}, 32'(valid_out), 32'(n != 0));
      if (n != 0) chk({tag, ":data"}, 32'(data_out), 32'(q[0]));
    end else begin
      chk({tag, ":valid"}, 32'(valid_out), 32'(m_valid));
      chk({tag, ":data"}, 32'(data_out), 32'(m_data));
    end
  endtask

  // Called right after the edge, using the pre-edge occupancy.
  task automatic model_step(input logic wr, input logic [DATA_W-1:0] din, input logic rd);
    bit m_full, m_empty, wacc, racc;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    wacc = wr && (!m_full || rd);
    racc = rd && !m_empty;
    if ((wr && m_full && !rd) || (rd && m_empty)) m_error = 1'b1;
    m_valid = racc;
    if (racc) m_data = q.pop_front();
    if (wacc) q.push_back(din);
  endtask

  // Starts and ends on a falling edge.
  task automatic cycle(input string tag, input logic wr, input logic [DATA_W-1:0] din,
                       input logic rd);
    wr_en = wr; data_in = din; rd_en = rd;
    @(posedge clk);
    model_step(wr, din, rd);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_error = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  initial begin
    // 1: reset state
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst:empty", 32'(empty), 32'd1);
    chk("rst:almost_empty", 32'(almost_empty), 32'd1);
    chk("rst:full", 32'(full), 32'd0);
    chk("rst:almost_full", 32'(almost_full), 32'd0);
    chk("rst:error", 32'(error), 32'd0);
    chk("rst:valid", 32'(valid_out), 32'd0);
    if (!FWFT) chk("rst:data", 32'(data_out), 32'd0);
    umbral_H = 3'd0;
    #1 chk("rst:af_at_zero", 32'(almost_full), 32'd1);
    umbral_H = 3'd6;
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);

    // 2: fill then drain in order
    for (int i = 1; i <= 8; i++) begin
      cycle("fill", 1'b1, DATA_W'(i), 1'b0);
      if (i == 3) chk("fill:ae_falls_3", 32'(almost_empty), 32'd0);
      if (i == 5) chk("fill:af_low_5", 32'(almost_full), 32'd0);
      if (i == 6) chk("fill:af_rises_6", 32'(almost_full), 32'd1);
      if (i == 7) chk("fill:full_low_7", 32'(full), 32'd0);
    end
    chk("fill:full_8", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      if (FWFT) chk("drain:head", 32'(data_out), 32'(i));
      cycle("drain", 1'b0, '0, 1'b1);
      if (!FWFT) chk("drain:word", 32'(data_out), 32'(i));
    end

    // 3: overflow
    for (int i = 1; i <= 8; i++) cycle("fill3", 1'b1, DATA_W'(i), 1'b0);
    cycle("ovf", 1'b1, 6'h3F, 1'b0);
    chk("ovf:error", 32'(error), 32'd1);
    chk("ovf:full", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cycle("ovf_drain", 1'b0, '0, 1'b1);
      if (!FWFT) chk("ovf_drain:word", 32'(data_out), 32'(i));
    end

    // 4: simultaneous push/pop when full, from a clean error state
    reset_L = 1'b0; model_reset();
    @(negedge clk); reset_L = 1'b1; @(negedge clk);
    for (int i = 1; i <= 8; i++) cycle("fill4", 1'b1, DATA_W'(i), 1'b0);
    cycle("wr_rd_full", 1'b1, 6'h2A, 1'b1);
    chk("wr_rd_full:full", 32'(full), 32'd1);
    chk("wr_rd_full:error", 32'(error), 32'd0);
    if (!FWFT) chk("wr_rd_full:popped", 32'(data_out), 32'h01);
    for (int i = 0; i < 8; i++) cycle("drain4", 1'b0, '0, 1'b1);
    if (!FWFT) chk("drain4:last", 32'(data_out), 32'h2A);
    chk("drain4:empty", 32'(empty), 32'd1);

    // 5: underflow, then push+pop while empty
    cycle("udf", 1'b0, '0, 1'b1);
    chk("udf:valid", 32'(valid_out), 32'd0);
    chk("udf:error", 32'(error), 32'd1);
    cycle("wr_rd_empty", 1'b1, 6'h15, 1'b1);
    chk("wr_rd_empty:empty", 32'(empty), 32'd0);
    chk("wr_rd_empty:error", 32'(error), 32'd1);

    // 6: asynchronous reset with entries stored
    for (int i = 0; i < 3; i++) cycle("fill6", 1'b1, DATA_W'(i + 9), 1'b0);
    chk("fill6:count4_ae", 32'(almost_empty), 32'd0);
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    chk("async:empty", 32'(empty), 32'd1);
    chk("async:full", 32'(full), 32'd0);
    chk("async:almost_empty", 32'(almost_empty), 32'd1);
    chk("async:error", 32'(error), 32'd0);
    chk("async:valid", 32'(valid_out), 32'd0);
    @(negedge clk); reset_L = 1'b1; @(negedge clk);

    // Random traffic with thresholds changed between bursts
    for (int b = 0; b < 8; b++) begin
      int wr_pct, rd_pct;
      umbral_L = 3'($urandom_range(0, 7));
      umbral_H = 3'($urandom_range(0, 7));
      wr_pct = $urandom_range(20, 80);
      rd_pct = $urandom_range(20, 80);
      #1 check_all("thr_change");
      @(negedge clk);
      for (int c = 0; c < 60; c++) begin
        cycle("rand",
              ($urandom_range(0, 99) < wr_pct),
              DATA_W'($urandom_range(0, 63)),
              ($urandom_range(0, 99) < rd_pct));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
